// File: rtl/mem_write_checker.sv
// Purpose: snoops a data-memory store bus and checks the new stores, in order,
//          against a programmable table of expected (addr, data) pairs. It
//          counts data mismatches, measures run length and ends the run on completion or timeout.
// Ports:   clk/rst (async active-low); addr/data/wen snooped bus; cfg_* table
//          programming and run size; start; error_num/duration/finish/pass/timeout status.
module mem_write_checker #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int DUR_W   = 16,
  parameter int ERR_W   = 8,
  parameter int TIMEOUT = 50000,
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NUM_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wen,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [NUM_W-1:0]  cfg_num,
  input  logic              start,
  output logic [ERR_W-1:0]  error_num,
  output logic [DUR_W-1:0]  duration,
  output logic              finish,
  output logic              pass,
  output logic              timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e             state_q, state_d;
  logic               wen_q, wen_d;
  logic [ADDR_W-1:0]  exp_addr_q [DEPTH];
  logic [ADDR_W-1:0]  exp_addr_d [DEPTH];
  logic [DATA_W-1:0]  exp_data_q [DEPTH];
  logic [DATA_W-1:0]  exp_data_d [DEPTH];
  logic [NUM_W-1:0]   ptr_q, ptr_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic [ERR_W-1:0]   error_num_q, error_num_d;
  logic [DUR_W-1:0]   duration_q, duration_d;
  logic               timeout_q, timeout_d;

  logic               running;
  logic               store_evt;
  logic               hit;
  logic               complete;
  logic               timeout_hit;
  logic               cfg_ok;
  logic [IDX_W-1:0]   ptr_idx;
  logic [NUM_W-1:0]   ptr_nxt;
  logic [NUM_W-1:0]   num_clamped;

  // A stalled store keeps wen high for several cycles; only its rising edge counts.
  assign store_evt   = wen & ~wen_q;
  assign running     = (state_q == ST_RUN);
  assign ptr_idx     = ptr_q[IDX_W-1:0];
  assign ptr_nxt     = ptr_q + NUM_W'(1);
  assign cfg_ok      = (32'(cfg_idx) < DEPTH);
  assign num_clamped = (32'(cfg_num) > DEPTH) ? NUM_W'(DEPTH) : cfg_num;

  // Stores to other addresses (stack, scratch) are not errors; they are skipped.
  // An empty table performs no comparisons at all.
  assign hit         = running && (num_q != '0) && store_evt && (addr == exp_addr_q[ptr_idx]);
  assign complete    = running && ((num_q == '0) || (hit && (ptr_nxt == num_q)));
  // Completion on the last allowed cycle beats the timeout.
  assign timeout_hit = running && (duration_q == DUR_W'(TIMEOUT - 1)) && !complete;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
      ST_RUN:           if (complete || timeout_hit) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Output decode, from registered state only
  always_comb begin
    finish    = (state_q == ST_DONE);
    pass      = finish && (error_num_q == '0) && !timeout_q;
    error_num = error_num_q;
    duration  = duration_q;
    timeout   = timeout_q;
  end

  // Datapath next values
  always_comb begin
    wen_d       = wen;
    exp_addr_d  = exp_addr_q;
    exp_data_d  = exp_data_q;
    ptr_d       = ptr_q;
    num_d       = num_q;
    error_num_d = error_num_q;
    duration_d  = duration_q;
    timeout_d   = timeout_q;
    if (!running) begin
      // A table write in the same cycle as start still lands.
      if (cfg_we && cfg_ok) begin
        exp_addr_d[cfg_idx] = cfg_addr;
        exp_data_d[cfg_idx] = cfg_data;
      end
      if (start) begin
        ptr_d       = '0;
        num_d       = num_clamped;
        error_num_d = '0;
        duration_d  = '0;
        timeout_d   = 1'b0;
      end
    end else begin
      duration_d = duration_q + DUR_W'(1);
      if (hit) begin
        ptr_d = ptr_nxt;
        if ((data != exp_data_q[ptr_idx]) && (error_num_q != '1))
          error_num_d = error_num_q + ERR_W'(1);
      end
      if (timeout_hit) timeout_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_q       <= 1'b0;
      exp_addr_q  <= '{default: '0};
      exp_data_q  <= '{default: '0};
      ptr_q       <= '0;
      num_q       <= '0;
      error_num_q <= '0;
      duration_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      wen_q       <= wen_d;
      exp_addr_q  <= exp_addr_d;
      exp_data_q  <= exp_data_d;
      ptr_q       <= ptr_d;
      num_q       <= num_d;
      error_num_q <= error_num_d;
      duration_q  <= duration_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: two instances share all inputs, one with a long
// timeout and 8-bit error count, one with TIMEOUT=20 and a 2-bit error count.
// Expected results come from an order-walking model over the recorded stimulus.
module tb_mem_write_checker;
  localparam int AW = 30, DW = 32, DEP = 5;
  localparam int TA = 200, TBT = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] addr, cfg_addr;
  logic [DW-1:0] data, cfg_data;
  logic          wen, cfg_we, start;
  logic [2:0]    cfg_idx, cfg_num;

  logic [7:0]  a_err;
  logic [1:0]  b_err;
  logic [15:0] a_dur, b_dur;
  logic        a_fin, a_pass, a_to, b_fin, b_pass, b_to;

  mem_write_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .DUR_W(16), .ERR_W(8), .TIMEOUT(TA)) dut_a (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_num(cfg_num), .start(start),
    .error_num(a_err), .duration(a_dur), .finish(a_fin), .pass(a_pass), .timeout(a_to));

  mem_write_checker #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .DUR_W(16), .ERR_W(2), .TIMEOUT(TBT)) dut_b (
    .clk(clk), .rst(rst), .addr(addr), .data(data), .wen(wen),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_num(cfg_num), .start(start),
    .error_num(b_err), .duration(b_dur), .finish(b_fin), .pass(b_pass), .timeout(b_to));

  int total = 0;
  int bad   = 0;

  // Reference table and per-cycle stimulus (index 0 = the start cycle).
  logic [AW-1:0] m_addr [DEP];
  logic [DW-1:0] m_data [DEP];
  logic          st_wen  [64];
  logic [AW-1:0] st_addr [64];
  logic [DW-1:0] st_data [64];
  int            st_len;

  // Optional table write presented in the start cycle.
  logic          sc_we = 1'b0;
  int            sc_idx;
  logic [AW-1:0] sc_addr;
  logic [DW-1:0] sc_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "/a_err"}, 32'(a_err), 0);
    chk({tag, "/a_dur"}, 32'(a_dur), 0);
    chk({tag, "/a_fin"}, 32'(a_fin), 0);
    chk({tag, "/a_pass"}, 32'(a_pass), 0);
    chk({tag, "/a_to"}, 32'(a_to), 0);
    chk({tag, "/b_err"}, 32'(b_err), 0);
    chk({tag, "/b_dur"}, 32'(b_dur), 0);
    chk({tag, "/b_fin"}, 32'(b_fin), 0);
    chk({tag, "/b_pass"}, 32'(b_pass), 0);
    chk({tag, "/b_to"}, 32'(b_to), 0);
  endtask

  task automatic cfg_write(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
    if (idx < DEP) begin
      m_addr[idx] = a;
      m_data[idx] = d;
    end
  endtask

  task automatic clr_stim(input int len);
    st_len = len;
    for (int c = 0; c < 64; c++) begin
      st_wen[c]  = 1'b0;
      st_addr[c] = AW'($urandom);
      st_data[c] = DW'($urandom);
    end
  endtask

  task automatic put(input int c, input int n, input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int i = c; i < c + n; i++) begin
      st_wen[i] = 1'b1; st_addr[i] = a; st_data[i] = d;
    end
  endtask

  // Walk the rising-edge stores in order, matching the table entry by entry.
  function automatic void model(input int t_lim, input int emax, input int num,
                                output int eff, output int err, output bit to);
    int p, endc;
    p = 0; err = 0;
    endc = (num == 0) ? 1 : 1000000;
    if (num > 0) begin
      for (int c = 1; c <= st_len; c++) begin
        if (c > t_lim) break;
        if (st_wen[c] && !st_wen[c-1] && st_addr[c] == m_addr[p]) begin
          if (st_data[c] != m_data[p] && err < emax) err++;
          p++;
          if (p == num) begin
            endc = c;
            break;
          end
        end
      end
    end
    to  = (endc > t_lim);
    eff = to ? t_lim : endc;
  endfunction

  task automatic run_case(input string tag, input int num_raw, input bit noise);
    int num, effa, erra, effb, errb, kmax;
    bit toa, tob;
    num = (num_raw > DEP) ? DEP : num_raw;
    if (sc_we && sc_idx < DEP) begin
      m_addr[sc_idx] = sc_addr;
      m_data[sc_idx] = sc_data;
    end
    model(TA, 255, num, effa, erra, toa);
    model(TBT, 3, num, effb, errb, tob);
    cfg_num = 3'(num_raw); start = 1'b1;
    cfg_we = sc_we; cfg_idx = 3'(sc_idx); cfg_addr = sc_addr; cfg_data = sc_data;
    wen = st_wen[0]; addr = st_addr[0]; data = st_data[0];
    tick();
    start = 1'b0; cfg_we = 1'b0; sc_we = 1'b0;
    kmax = ((effa > effb) ? effa : effb) + 2;
    for (int k = 1; k <= kmax; k++) begin
      wen  = (k <= st_len) ? st_wen[k] : 1'b0;
      addr = (k <= st_len) ? st_addr[k] : AW'($urandom);
      data = (k <= st_len) ? st_data[k] : DW'($urandom);
      if (noise && k <= 2) begin
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_addr = AW'($urandom); cfg_data = DW'($urandom);
        start = 1'b1;
      end else begin
        cfg_we = 1'b0; start = 1'b0;
      end
      tick();
      chk($sformatf("%s/a_fin@%0d", tag, k), 32'(a_fin), 32'(k >= effa));
      chk($sformatf("%s/b_fin@%0d", tag, k), 32'(b_fin), 32'(k >= effb));
      chk($sformatf("%s/a_dur@%0d", tag, k), 32'(a_dur), 32'((k < effa) ? k : effa));
      chk($sformatf("%s/b_dur@%0d", tag, k), 32'(b_dur), 32'((k < effb) ? k : effb));
    end
    wen = 1'b0; cfg_we = 1'b0; start = 1'b0;
    chk({tag, "/a_err"}, 32'(a_err), 32'(erra));
    chk({tag, "/a_to"}, 32'(a_to), 32'(toa));
    chk({tag, "/a_pass"}, 32'(a_pass), 32'(erra == 0 && !toa));
    chk({tag, "/b_err"}, 32'(b_err), 32'(errb));
    chk({tag, "/b_to"}, 32'(b_to), 32'(tob));
    chk({tag, "/b_pass"}, 32'(b_pass), 32'(errb == 0 && !tob));
  endtask

  initial begin
    rst = 1'b0; wen = 1'b0; addr = '0; data = '0; cfg_we = 1'b0; cfg_idx = '0;
    cfg_addr = '0; cfg_data = '0; cfg_num = '0; start = 1'b0;
    sc_idx = 0; sc_addr = '0; sc_data = '0;
    for (int i = 0; i < DEP; i++) begin m_addr[i] = '0; m_data[i] = '0; end
    #1;
    tick(); tick();
    chk_zero("reset");
    rst = 1'b1;
    tick();

    // Single entry, store in the 3rd RUN cycle
    cfg_write(0, 30'd0, 32'd6);
    clr_stim(5); put(3, 1, 30'd0, 32'd6);
    run_case("single", 1, 1'b0);

    // Stalled store counted once, then the second store
    cfg_write(0, 30'd4, 32'd10); cfg_write(1, 30'd8, 32'd20);
    clr_stim(12); put(2, 5, 30'd4, 32'd10); put(9, 1, 30'd8, 32'd20);
    run_case("stall", 2, 1'b0);

    // Swapped order never completes
    clr_stim(12); put(2, 1, 30'd8, 32'd20); put(4, 5, 30'd4, 32'd10);
    run_case("swapped", 2, 1'b0);

    // Held wen must not satisfy a repeated entry early
    cfg_write(1, 30'd4, 32'd10); cfg_write(2, 30'd8, 32'd20);
    clr_stim(12); put(2, 5, 30'd4, 32'd10); put(8, 1, 30'd4, 32'd10); put(10, 1, 30'd8, 32'd20);
    run_case("stall_dup", 3, 1'b0);

    // Data mismatches on entries 0 and 2
    cfg_write(0, 30'h10, 32'd1); cfg_write(1, 30'h11, 32'd2); cfg_write(2, 30'h12, 32'd3);
    clr_stim(6); put(1, 1, 30'h10, 32'd9); put(3, 1, 30'h11, 32'd2); put(5, 1, 30'h12, 32'd7);
    run_case("mismatch", 3, 1'b0);

    // Unrelated stores interleaved with the expected ones
    cfg_write(0, 30'd4, 32'd10); cfg_write(1, 30'd8, 32'd20);
    clr_stim(24);
    for (int i = 0; i < 5; i++) put(1 + 2 * i, 1, 30'(100 + i), 32'(i));
    put(11, 1, 30'd4, 32'd10);
    for (int i = 0; i < 5; i++) put(13 + 2 * i, 1, 30'(105 + i), 32'(i));
    put(23, 1, 30'd8, 32'd20);
    run_case("unrelated", 2, 1'b0);

    // Timeout, and completion on the exact last cycle / one past it
    clr_stim(25);
    run_case("timeout", 1, 1'b0);
    clr_stim(20); put(20, 1, 30'd4, 32'd10);
    run_case("last_cycle", 1, 1'b0);
    clr_stim(21); put(21, 1, 30'd4, 32'd10);
    run_case("past_last", 1, 1'b0);

    // Empty run
    clr_stim(3);
    run_case("num0", 0, 1'b0);

    // Error count saturation, cfg_num clamp, out-of-range cfg_idx ignored
    for (int i = 0; i < DEP; i++) cfg_write(i, 30'(32 + i), 32'(i));
    cfg_write(6, 30'd32, 32'd77);
    clr_stim(10);
    for (int i = 0; i < DEP; i++) put(1 + 2 * i, 1, 30'(32 + i), 32'(50 + i));
    run_case("saturate", 7, 1'b0);
    clr_stim(10);
    for (int i = 0; i < DEP; i++) put(1 + 2 * i, 1, 30'(32 + i), 32'(i));
    run_case("clamp", 7, 1'b0);

    // Table write alongside start, then used by the next run
    sc_we = 1'b1; sc_idx = 3; sc_addr = 30'd900; sc_data = 32'd901;
    clr_stim(4); put(2, 1, 30'd32, 32'd0);
    run_case("start_cfg", 1, 1'b0);
    clr_stim(8); put(1, 1, 30'd32, 32'd0); put(3, 1, 30'd33, 32'd1);
    put(5, 1, 30'd34, 32'd2); put(7, 1, 30'd900, 32'd901);
    run_case("start_cfg_use", 4, 1'b0);

    // cfg_we and start during RUN are ignored
    clr_stim(6); put(5, 1, 30'd32, 32'd0);
    run_case("noise", 1, 1'b1);

    // Random tables and traffic
    for (int r = 0; r < 12; r++) begin
      int len;
      for (int i = 0; i < DEP; i++) cfg_write(i, AW'($urandom_range(0, 7)), DW'($urandom_range(0, 3)));
      len = $urandom_range(10, 40);
      clr_stim(len);
      for (int c = 0; c <= len; c++) begin
        st_wen[c] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 1) == 1) begin
          int e;
          e = $urandom_range(0, DEP - 1);
          st_addr[c] = m_addr[e];
          st_data[c] = ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : m_data[e];
        end else begin
          st_addr[c] = AW'($urandom_range(0, 7));
          st_data[c] = DW'($urandom_range(0, 3));
        end
      end
      run_case($sformatf("rand%0d", r), int'($urandom_range(0, 7)), 1'b0);
    end

    // Reset in the middle of a run
    cfg_write(0, 30'd1, 32'd1); cfg_write(1, 30'd2, 32'd2);
    cfg_num = 3'd2; start = 1'b1; wen = 1'b0;
    tick();
    start = 1'b0; wen = 1'b1; addr = 30'd1; data = 32'd99;
    tick();
    wen = 1'b0;
    tick(); tick(); tick();
    chk("midrun/a_err", 32'(a_err), 1);
    chk("midrun/a_dur", 32'(a_dur), 4);
    chk("midrun/b_fin", 32'(b_fin), 0);
    rst = 1'b0;
    #1;
    chk_zero("midrun_rst");
    tick();
    rst = 1'b1;
    for (int i = 0; i < DEP; i++) begin m_addr[i] = '0; m_data[i] = '0; end
    tick();

    // Table is cleared by reset: entry 0 is (0, 0)
    clr_stim(4); put(2, 1, 30'd0, 32'd0);
    run_case("after_rst", 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

Parametrised self-checking monitor for the pipelined MIPS test benches. It snoops the data-memory write bus (`addr`, `data`, `wen`) and compares each new store against a programmable table of up to DEPTH expected (address, data) pairs in order. It counts mismatches and measures run length in cycles, and enforces a cycle timeout. It raises `finish` and `pass`/`timeout` status for the simulation top level. A D-cache stall holds `wen` high across several cycles; each store is counted once, on its `wen` rising edge.

## Interface
- ADDR_W, 30, word-address width of the snooped bus
- DATA_W, 32, data width of the snooped bus
- DEPTH, 8, maximum number of expected entries (≥1)
- DUR_W, 16, width of `duration`
- ERR_W, 8, width of `error_num`
- TIMEOUT, 50000, RUN-cycle limit; must satisfy 1 ≤ TIMEOUT ≤ 2^DUR_W−1
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- addr  input  ADDR_W  snooped store address
- data  input  DATA_W  snooped store data
- wen  input  1  snooped store enable (may stay high for multiple cycles)
- cfg_we  input  1  write expected entry `cfg_idx` (IDLE or DONE only)
- cfg_idx  input  clog2(DEPTH)  entry index; values ≥ DEPTH ignored
- cfg_addr  input  ADDR_W  expected address
- cfg_data  input  DATA_W  expected data
- cfg_num  input  clog2(DEPTH+1)  entries in use, sampled on `start`; values > DEPTH clamp to DEPTH
- start  input  1  begin a check run (IDLE or DONE only)
- error_num  output  ERR_W  data mismatches this run, saturating
- duration  output  DUR_W  RUN cycles elapsed
- finish  output  1  high in DONE
- pass  output  1  finish & error_num==0 & ~timeout
- timeout  output  1  run ended by TIMEOUT

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE. All outputs are 0 at reset, and the table, pointer, `num_q` and `wen_q` clear to 0.
- Store event: `wen & ~wen_q`. `wen_q` is a register updated every cycle in every state. A `wen` that is already high when RUN is entered therefore produces no event.
- IDLE or DONE, `start`=1:
  - go to RUN.
  - ptr←0, error_num←0, duration←0, timeout←0.
  - num_q←clamped `cfg_num`.
  - `start` has priority over `cfg_we` in the same cycle; that cfg write is still performed.
- In RUN, `cfg_we` and `start` are ignored.
- RUN, each cycle:
  - duration←duration+1.
  - On a store event, compare against entry[ptr]:
    - addr≠exp_addr: the store is ignored; ptr and error_num are unchanged. Stack and other traffic pass freely.
    - addr==exp_addr and data==exp_data: ptr←ptr+1.
    - addr==exp_addr and data≠exp_data: ptr←ptr+1 and error_num←error_num+1, saturating at 2^ERR_W−1.
- Completion: in RUN, if num_q==0, or an advancing event makes ptr+1==num_q, go to DONE with timeout=0.
- Timeout: in RUN with duration==TIMEOUT−1 and no completion this cycle, go to DONE with timeout←1.
  - If completion and timeout occur in the same cycle, completion wins.
- DONE: error_num, duration and timeout are held. Store events are ignored. `finish`=1.
- Reset mid-run: returns immediately to IDLE. The table is cleared and must be reprogrammed.

## Timing
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.
- An event in cycle t updates ptr and error_num at edge t+1.
- A completing event in cycle t gives `finish`=1 from edge t+1.
- `duration` counts the edges spent leaving RUN cycles.
  - Example: start sampled at edge E0 and the final event in the first RUN cycle gives DONE at E1 with duration=1.
  - A timed-out run ends with duration=TIMEOUT.
- A cfg write at edge t is visible to a `start` sampled at edge t+1 or later.
- `pass` and `finish` change on the same edge.

## Test plan
- Single-entry run:
  - Program entry0 = (0, 6), cfg_num=1, start. Drive a store (0, 6) in the 3rd RUN cycle.
  - Expect finish=1, pass=1, error_num=0, duration=3.
- Stall debounce and ordering:
  - Program entries (4, 10) and (8, 20), num=2.
  - Drive (4, 10) with `wen` held high for 5 cycles, then (8, 20).
  - Expect exactly 2 events, pass=1.
  - Drive the same stores in swapped order and expect finish=0 until timeout.
- Mismatch counting:
  - 3 entries; data wrong on entries 0 and 2.
  - Expect finish=1, error_num=2, pass=0, timeout=0.
- Unrelated stores:
  - Interleave 10 stores to addresses not in the table.
  - Expect no error_num change and pass=1 after the expected stores.
- Timeout:
  - TIMEOUT=20, one entry, never written.
  - Expect finish=1 and timeout=1 at duration=20, pass=0. Completion in exactly the 20th cycle gives timeout=0.
- Edge cases:
  - cfg_num=0 with start gives DONE next edge, pass=1, duration=1.
  - Reset asserted mid-run gives all outputs 0 immediately.
  - `start` in DONE reruns with cleared counters.
